// File: rtl/isp_req_pkg.sv
`default_nettype none
// ============================================================================
// Module      : isp_req_pkg
// Description : Shared types and constants for the ISP request generator:
//               FSM state encoding, LFSR width/mask, parameter defaults and
//               the Galois LFSR step function.
// Revision    : 1.0 - initial release
// ============================================================================
package isp_req_pkg;

   localparam int                LFSR_W    = 16;
   localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

   localparam int                DEF_PAT_NUM = 3;
   localparam int                DEF_NUM_PIC = 15;
   localparam int                DEF_PIC_W   = 4;
   localparam int                DEF_MAX_DLY = 4;
   localparam int                DEF_TIMEOUT = 1000;
   localparam int                DEF_DATA_W  = 8;
   localparam logic [LFSR_W-1:0] DEF_SEED    = 16'hACE1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT  = 3'd1,
      ST_DELAY = 3'd2,
      ST_ISSUE = 3'd3,
      ST_WAIT  = 3'd4,
      ST_DRAIN = 3'd5,
      ST_DONE  = 3'd6,
      ST_FAIL  = 3'd7
   } state_t;

   // Right-shifting Galois step: feedback taps are applied when bit 0 falls out.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
      lfsr_step = (v >> 1) ^ (v[0] ? LFSR_MASK : '0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/isp_req_gen_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : isp_lfsr16
// Description : 16-bit Galois LFSR that loads its seed on reset and steps
//               once for every cycle in which adv is high.
// Revision    : 1.0 - initial release
// ============================================================================
module isp_lfsr16
   import isp_req_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              adv,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] value
);

   // Seed on reset, otherwise advance on request.
   always_ff @(posedge clk) begin
      if (rst) begin
         value <= seed;
      end else if (adv) begin
         value <= lfsr_step(value);
      end
   end

endmodule
`default_nettype wire

// File: rtl/isp_req_gen.sv
`default_nettype none
// ============================================================================
// Module      : isp_req_gen
// Description : Pseudo-random request generator for an ISP block. Issues
//               PAT_NUM requests separated by random gaps, measures response
//               latency and flags init, overlap and timeout errors.
//               Optional feature macro: ISP_REQ_GEN_CHECKSUM_EN enables a
//               16-bit running sum of response data.
// Revision    : 1.0 - initial release
// ============================================================================
module isp_req_gen
   import isp_req_pkg::*;
#(
   parameter int          PAT_NUM = DEF_PAT_NUM,
   parameter int          NUM_PIC = DEF_NUM_PIC,
   parameter int          PIC_W   = DEF_PIC_W,
   parameter int          MAX_DLY = DEF_MAX_DLY,
   parameter int          TIMEOUT = DEF_TIMEOUT,
   parameter int          DATA_W  = DEF_DATA_W,
   parameter logic [15:0] SEED    = DEF_SEED
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              in_valid,
   output logic [PIC_W-1:0]  in_pic_no,
   output logic              in_mode,
   output logic [1:0]        in_ratio_mode,
   input  logic              out_valid,
   input  logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done,
   output logic              timeout_err,
   output logic              overlap_err,
   output logic              init_err,
   output logic [15:0]       pat_cnt,
   output logic [15:0]       last_latency,
   output logic [31:0]       total_latency,
   output logic [15:0]       checksum
);

   localparam logic [15:0] TO_LIM  = 16'(TIMEOUT - 1);
   localparam logic [15:0] PAT_LIM = 16'(PAT_NUM);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] lfsr;
   logic        lfsr_adv;
   logic [15:0] dly_cnt;
   logic [15:0] lat_cnt;
   logic [15:0] gap;
   logic [32:0] tot_sum;
   logic        start_ok;
   logic        enter_delay;
   logic        init_bad;

   assign start_ok    = start && (state == ST_IDLE || state == ST_DONE || state == ST_FAIL);
   assign init_bad    = out_valid || (out_data != '0);
   assign enter_delay = (state_nxt == ST_DELAY) && (state != ST_DELAY);
   assign lfsr_adv    = enter_delay || (state == ST_ISSUE);
   assign gap         = 16'(lfsr % 16'(MAX_DLY)) + 16'd1;
   assign tot_sum     = {1'b0, total_latency} + 33'(lat_cnt);

   isp_lfsr16 u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .adv   (lfsr_adv),
      .seed  (SEED),
      .value (lfsr)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; overlap in ISSUE wins over the move to WAIT.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE, ST_FAIL: if (start) state_nxt = ST_INIT;
         ST_INIT:  state_nxt = init_bad ? ST_FAIL : ST_DELAY;
         ST_DELAY: if (dly_cnt <= 16'd1) state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = out_valid ? ST_FAIL : ST_WAIT;
         ST_WAIT: begin
            if (out_valid)              state_nxt = ST_DRAIN;
            else if (lat_cnt == TO_LIM) state_nxt = ST_FAIL;
         end
         ST_DRAIN: if (!out_valid) state_nxt = (pat_cnt == PAT_LIM) ? ST_DONE : ST_DELAY;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Request fields and status decoded from the current state.
   always_comb begin
      in_valid      = 1'b0;
      in_pic_no     = '0;
      in_mode       = 1'b0;
      in_ratio_mode = 2'b00;
      busy          = 1'b0;
      done          = 1'b0;
      case (state)
         ST_ISSUE: begin
            in_valid      = 1'b1;
            in_pic_no     = PIC_W'(lfsr % 16'(NUM_PIC)) + PIC_W'(1);
            in_mode       = lfsr[0];
            in_ratio_mode = lfsr[2:1];
            busy          = 1'b1;
         end
         ST_INIT, ST_DELAY, ST_WAIT, ST_DRAIN: busy = 1'b1;
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   // Gap/latency counters, statistics and sticky error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         dly_cnt       <= '0;
         lat_cnt       <= '0;
         pat_cnt       <= '0;
         last_latency  <= '0;
         total_latency <= '0;
         timeout_err   <= 1'b0;
         overlap_err   <= 1'b0;
         init_err      <= 1'b0;
      end else begin
         if (start_ok) begin
            pat_cnt       <= '0;
            last_latency  <= '0;
            total_latency <= '0;
            timeout_err   <= 1'b0;
            overlap_err   <= 1'b0;
            init_err      <= 1'b0;
         end
         if (enter_delay) begin
            dly_cnt <= gap;
         end else if (state == ST_DELAY) begin
            dly_cnt <= dly_cnt - 16'd1;
         end
         case (state)
            ST_INIT:  if (init_bad) init_err <= 1'b1;
            ST_ISSUE: begin
               lat_cnt <= '0;
               if (out_valid) overlap_err <= 1'b1;
            end
            ST_WAIT: begin
               if (out_valid) begin
                  last_latency  <= lat_cnt;
                  total_latency <= tot_sum[32] ? '1 : tot_sum[31:0];
                  pat_cnt       <= pat_cnt + 16'd1;
               end else if (lat_cnt == TO_LIM) begin
                  timeout_err <= 1'b1;
               end else begin
                  lat_cnt <= lat_cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ISP_REQ_GEN_CHECKSUM_EN
   logic [15:0] csum;

   // Modular sum of response data seen while a response is being collected.
   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         csum <= '0;
      end else if ((state == ST_WAIT || state == ST_DRAIN) && out_valid) begin
         csum <= csum + 16'(out_data);
      end
   end

   assign checksum = csum;
`else
   assign checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_isp_req_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_isp_req_gen
// Description : Self-checking bench for isp_req_gen: a cycle model compared
//               on every cycle plus directed literal checks per scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_isp_req_gen;

   localparam int PAT_NUM = 3;
   localparam int NUM_PIC = 15;
   localparam int PIC_W   = 4;
   localparam int MAX_DLY = 4;
   localparam int TIMEOUT = 1000;
   localparam int DATA_W  = 8;
   localparam logic [15:0] SEED = 16'hACE1;

`ifdef ISP_REQ_GEN_CHECKSUM_EN
   localparam logic [15:0] EXP_CS_A = 16'h05FA;
`else
   localparam logic [15:0] EXP_CS_A = 16'h0000;
`endif

   localparam int PH_IDLE = 0, PH_INIT = 1, PH_GAP = 2, PH_ISSUE = 3,
                  PH_WAIT = 4, PH_DRAIN = 5, PH_DONE = 6, PH_FAIL = 7;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              in_valid;
   logic [PIC_W-1:0]  in_pic_no;
   logic              in_mode;
   logic [1:0]        in_ratio_mode;
   logic              out_valid = 1'b0;
   logic [DATA_W-1:0] out_data = '0;
   logic              busy, done, timeout_err, overlap_err, init_err;
   logic [15:0]       pat_cnt, last_latency, checksum;
   logic [31:0]       total_latency;

   isp_req_gen #(
      .PAT_NUM(PAT_NUM), .NUM_PIC(NUM_PIC), .PIC_W(PIC_W), .MAX_DLY(MAX_DLY),
      .TIMEOUT(TIMEOUT), .DATA_W(DATA_W), .SEED(SEED)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .in_pic_no(in_pic_no), .in_mode(in_mode),
      .in_ratio_mode(in_ratio_mode), .out_valid(out_valid), .out_data(out_data),
      .busy(busy), .done(done), .timeout_err(timeout_err),
      .overlap_err(overlap_err), .init_err(init_err), .pat_cnt(pat_cnt),
      .last_latency(last_latency), .total_latency(total_latency),
      .checksum(checksum)
   );

   always #5 clk = ~clk;

   // LFSR value after n steps from the seed.
   function automatic logic [15:0] lfsr_at(input int n);
      logic [15:0] v;
      v = SEED;
      for (int k = 0; k < n; k++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
      return v;
   endfunction

   // ---------------- responder (plays the downstream ISP) ----------------
   int          resp_lat = 5;
   int          resp_len = 2;
   logic [7:0]  resp_data = 8'hFF;
   logic [7:0]  force_data = 8'h00;
   bit          ovl_mode = 1'b0;
   int          zl = 0, hl = 0;
   bit          iv_prev = 1'b0;

   always @(posedge clk) begin
      #1;
      if (rst) begin
         zl = 0;
         hl = 0;
      end else if (iv_prev && !ovl_mode) begin
         zl = resp_lat;
         hl = resp_len;
      end
      if (ovl_mode) begin
         out_valid = in_valid;
         out_data  = '0;
      end else if (zl > 0) begin
         zl--;
         out_valid = 1'b0;
         out_data  = force_data;
      end else if (hl > 0) begin
         hl--;
         out_valid = 1'b1;
         out_data  = resp_data;
      end else begin
         out_valid = 1'b0;
         out_data  = force_data;
      end
      iv_prev = in_valid;
   end

   // ---------------- behavioural model ----------------
   // Request r uses LFSR step 2r for its gap and step 2r+1 for its fields.
   int          m_ph = PH_IDLE, m_req = 0, m_gap = 0, m_lat = 0, m_pat = 0, m_last = 0;
   longint      m_total = 0;
   logic [15:0] m_sum = '0;
   bit          m_to = 0, m_ov = 0, m_in = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_ph = PH_IDLE; m_req = 0; m_pat = 0; m_last = 0; m_total = 0;
         m_sum = '0; m_to = 0; m_ov = 0; m_in = 0;
      end else begin
         case (m_ph)
            PH_IDLE, PH_DONE, PH_FAIL: if (start) begin
               m_ph = PH_INIT; m_pat = 0; m_last = 0; m_total = 0;
               m_sum = '0; m_to = 0; m_ov = 0; m_in = 0;
            end
            PH_INIT: if (out_valid || out_data != 0) begin
               m_in = 1; m_ph = PH_FAIL;
            end else begin
               m_gap = int'(lfsr_at(2 * m_req) % MAX_DLY) + 1; m_ph = PH_GAP;
            end
            PH_GAP: begin
               m_gap--;
               if (m_gap == 0) m_ph = PH_ISSUE;
            end
            PH_ISSUE: begin
               m_req++;
               if (out_valid) begin m_ov = 1; m_ph = PH_FAIL; end
               else begin m_lat = 0; m_ph = PH_WAIT; end
            end
            PH_WAIT: if (out_valid) begin
               m_last = m_lat; m_pat++;
               m_total = m_total + m_lat;
               if (m_total > 64'hFFFF_FFFF) m_total = 64'hFFFF_FFFF;
`ifdef ISP_REQ_GEN_CHECKSUM_EN
               m_sum = m_sum + 16'(out_data);
`endif
               m_ph = PH_DRAIN;
            end else begin
               m_lat++;
               if (m_lat == TIMEOUT) begin m_to = 1; m_ph = PH_FAIL; end
            end
            PH_DRAIN: if (out_valid) begin
`ifdef ISP_REQ_GEN_CHECKSUM_EN
               m_sum = m_sum + 16'(out_data);
`endif
            end else if (m_pat == PAT_NUM) begin
               m_ph = PH_DONE;
            end else begin
               m_gap = int'(lfsr_at(2 * m_req) % MAX_DLY) + 1; m_ph = PH_GAP;
            end
            default: m_ph = PH_IDLE;
         endcase
      end
   end

   // ---------------- checking ----------------
   int n_cmp = 0, n_fail = 0, cyc = 0, n_iv = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Advance one cycle and compare every DUT output against the model.
   task automatic tick();
      logic [15:0]      v;
      logic [PIC_W-1:0] ep;
      logic             eiv, em, ebusy;
      logic [1:0]       er;
      @(negedge clk);
      cyc++;
      if (in_valid) n_iv++;
      eiv   = (m_ph == PH_ISSUE);
      v     = lfsr_at(2 * m_req + 1);
      ep    = eiv ? PIC_W'((v % NUM_PIC) + 1) : '0;
      em    = eiv ? v[0] : 1'b0;
      er    = eiv ? v[2:1] : 2'b00;
      ebusy = (m_ph == PH_INIT) || (m_ph == PH_GAP) || (m_ph == PH_ISSUE) ||
              (m_ph == PH_WAIT) || (m_ph == PH_DRAIN);
      check("req", {in_valid, in_mode, in_ratio_mode, 16'(in_pic_no)}, {eiv, em, er, 16'(ep)});
      check("status", {busy, done, timeout_err, overlap_err, init_err},
            {ebusy, (m_ph == PH_DONE), m_to, m_ov, m_in});
      check("stats", {pat_cnt, last_latency, checksum}, {16'(m_pat), 16'(m_last), m_sum});
      check("total", total_latency, 64'(m_total[31:0]));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_issue(input string nm, input int bound);
      int i;
      i = 0;
      while (!in_valid && i < bound) begin tick(); i++; end
      check(nm, in_valid, 1);
   endtask

   task automatic wait_idle(input string nm, input int bound);
      int i;
      i = 0;
      while (busy && i < bound) begin tick(); i++; end
      check(nm, busy, 0);
   endtask

   initial begin
      int c0, iv0;
      // reset state
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_in_valid", in_valid, 0);
      check("rst_pat_cnt", pat_cnt, 0);
      check("rst_errs", {timeout_err, overlap_err, init_err}, 0);
      rst = 1'b0;
      tick();

      // normal run: latency 5, two-cycle responses of 8'hFF
      resp_lat = 5; resp_len = 2; resp_data = 8'hFF;
      pulse_start();
      wait_issue("a_issue1", 20);
      check("a_pic1", in_pic_no, 9);
      check("a_mode1", in_mode, 0);
      check("a_ratio1", in_ratio_mode, 0);
      tick();
      wait_issue("a_issue2", 40);
      check("a_pic2", in_pic_no, 3);
      check("a_ratio2", in_ratio_mode, 2);
      wait_idle("a_end", 100);
      check("a_done", done, 1);
      check("a_last", last_latency, 5);
      check("a_total", total_latency, 15);
      check("a_pat", pat_cnt, 3);
      check("a_errs", {timeout_err, overlap_err, init_err}, 0);
      check("a_checksum", checksum, 64'(EXP_CS_A));

      // overlap: response arrives together with the request
      resp_len = 0; ovl_mode = 1'b1;
      pulse_start();
      wait_idle("o_end", 20);
      ovl_mode = 1'b0;
      check("o_overlap", overlap_err, 1);
      check("o_busy", busy, 0);
      check("o_done", done, 0);

      // timeout: no response at all
      pulse_start();
      wait_issue("t_issue", 20);
      c0 = cyc;
      while (!timeout_err && (cyc - c0) < 1100) tick();
      check("t_wait_cycles", cyc - c0 - 1, TIMEOUT);
      check("t_busy", busy, 0);
      check("t_overlap_clr", overlap_err, 0);

      // init error: nonzero data seen during INIT
      iv0 = n_iv;
      force_data = 8'h01;
      start = 1'b1;
      tick();
      start = 1'b0;
      force_data = 8'h00;
      tick();
      check("i_init_err", init_err, 1);
      check("i_timeout_clr", timeout_err, 0);
      repeat (10) tick();
      check("i_no_request", n_iv - iv0, 0);

      // reset in WAIT, then a fresh run from the seed
      resp_lat = 50; resp_len = 1;
      pulse_start();
      wait_issue("r_issue", 20);
      repeat (3) tick();
      check("r_in_wait", busy, 1);
      rst = 1'b1;
      tick();
      check("r_in_valid", in_valid, 0);
      check("r_busy", busy, 0);
      check("r_stats", {pat_cnt, last_latency}, 0);
      check("r_total", total_latency, 0);
      rst = 1'b0; resp_lat = 3;
      tick();
      pulse_start();
      wait_issue("r_issue2", 20);
      check("r_pic", in_pic_no, 9);
      check("r_mode", in_mode, 0);
      check("r_ratio", in_ratio_mode, 0);
      wait_idle("r_end", 100);
      check("r_done", done, 1);
      check("r_last", last_latency, 3);
      check("r_total2", total_latency, 9);
      check("r_pat", pat_cnt, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/isp_req_gen.md
ISP_REQ_GEN -- requirements
Module: isp_req_gen

Interface
REQ-001 The module SHALL have parameter PAT_NUM, default 3, meaning the number of requests issued per run (1..65535).
REQ-002 The module SHALL have parameter NUM_PIC, default 15, meaning in_pic_no is drawn from 1..NUM_PIC.
REQ-003 The module SHALL have parameter PIC_W, default 4, meaning the width of in_pic_no.
REQ-004 The module SHALL have parameter MAX_DLY, default 4, meaning the idle gap before each request is drawn from 1..MAX_DLY cycles.
REQ-005 The module SHALL have parameter TIMEOUT, default 1000, meaning the latency limit in cycles.
REQ-006 The module SHALL have parameter DATA_W, default 8, meaning the width of out_data.
REQ-007 The module SHALL have parameter SEED, default 16'hACE1 and nonzero, meaning the LFSR reset value.
REQ-008 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-009 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-010 Port start, input, 1 bit: one-cycle pulse that begins a run.
REQ-011 Outputs in_valid (1 bit), in_pic_no (PIC_W), in_mode (1 bit) and in_ratio_mode (2 bits) SHALL carry the request to the DUT.
REQ-012 Inputs out_valid (1 bit) and out_data (DATA_W) SHALL carry the DUT response.
REQ-013 Outputs busy, done, timeout_err, overlap_err and init_err SHALL each be 1 bit and report run status.
REQ-014 Outputs pat_cnt (16 bits), last_latency (16 bits), total_latency (32 bits) and checksum (16 bits) SHALL report statistics.

Function
REQ-015 The FSM SHALL use these states: IDLE, INIT, DELAY, ISSUE, WAIT, DRAIN, DONE and FAIL.
REQ-016 In IDLE, start SHALL move the FSM to INIT, clear the statistics and clear done.
REQ-017 A start pulse received in any state other than IDLE, DONE or FAIL SHALL be ignored.
REQ-018 INIT SHALL last 1 cycle and SHALL set init_err and go to FAIL if out_valid is not 0 or out_data is not 0; otherwise it SHALL go to DELAY.
REQ-019 On entry to DELAY, the gap SHALL be loaded as (lfsr mod MAX_DLY)+1, and the FSM SHALL move to ISSUE after that many cycles.
REQ-020 ISSUE SHALL last exactly 1 cycle and SHALL drive in_valid=1 with the following fields:
- in_pic_no = (lfsr mod NUM_PIC)+1
- in_mode = lfsr[0]
- in_ratio_mode = lfsr[2:1]
REQ-021 Whenever in_valid=0, in_pic_no, in_mode and in_ratio_mode SHALL be driven to 0.
REQ-022 The LFSR SHALL be a 16-bit Galois LFSR with mask 16'hB400 that advances once per DELAY entry and once per ISSUE cycle.
REQ-023 In WAIT, the latency counter SHALL count cycles with out_valid=0, so latency is 0 if out_valid=1 in the first WAIT cycle.
REQ-024 When out_valid=1 in WAIT, the module SHALL latch last_latency, add the latency to total_latency (saturating at 2^32-1), increment pat_cnt and go to DRAIN.
REQ-025 DRAIN SHALL hold while out_valid=1, and when out_valid falls it SHALL go to DONE if pat_cnt==PAT_NUM, else to DELAY.
REQ-026 If the latency counter reaches TIMEOUT in WAIT, the module SHALL set timeout_err and go to FAIL.
REQ-027 If out_valid=1 in any cycle in which in_valid=1, the module SHALL set overlap_err and go to FAIL; this check SHALL take precedence over the WAIT transition.
REQ-028 busy SHALL be 1 in INIT, DELAY, ISSUE, WAIT and DRAIN, and 0 otherwise.
REQ-029 DONE SHALL assert done=1, and done SHALL stay 1 until the next start or reset.
REQ-030 FAIL SHALL hold its error flags until the next start or reset, and a start from DONE or FAIL SHALL behave as a start from IDLE.

Reset
REQ-031 On reset:
- the FSM SHALL go to IDLE;
- the LFSR SHALL load SEED;
- all counters, flags and outputs SHALL go to 0.
REQ-032 A reset asserted mid-run SHALL abort the run within 1 cycle, and in_valid SHALL be 0 in the cycle after rst is sampled high.

Configuration
REQ-033 With ISP_REQ_GEN_CHECKSUM_EN defined, checksum SHALL accumulate the 16-bit modular sum of the zero-extended out_data over every out_valid=1 cycle in WAIT and DRAIN.
REQ-034 With ISP_REQ_GEN_CHECKSUM_EN undefined, checksum SHALL be tied to 0 and the accumulator SHALL not be instantiated.

Structure
REQ-035 Package isp_req_pkg SHALL hold the FSM state enum, the LFSR mask and width constants, and the default parameter constants.
REQ-036 The LFSR SHALL be a sub-module named isp_lfsr16 with ports clk, rst, adv, seed and value.

Verification
REQ-037 The bench SHALL cover these scenarios:
- PAT_NUM=3, DUT responding with out_valid 5 cycles after each request -> last_latency=5, total_latency=15, pat_cnt=3, done=1, no errors.
- DUT asserting out_valid together with in_valid -> overlap_err=1, FSM in FAIL, busy=0.
- DUT never responding, TIMEOUT=1000 -> timeout_err=1 exactly 1000 WAIT cycles after the request.
- out_data=8'h01 driven in the INIT cycle -> init_err=1, in_valid never asserted.
- rst asserted in WAIT, then start -> all statistics are 0, and the first request uses the SEED-derived fields again.
- With ISP_REQ_GEN_CHECKSUM_EN defined, 3 responses of 2 cycles each with out_data=8'hFF -> checksum=16'h05FA.
